// File: rtl/facq_pkg.sv
// Shared definitions for the acquisition correlator stages: default widths,
// the correlator state encoding and the saturation-limit helpers.
package facq_pkg;

  localparam int FACQ_SAMPLE_WIDTH = 3;
  localparam int FACQ_ACC_WIDTH    = 24;
  localparam int FACQ_LEN_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } facq_corr_state_t;

  // Symmetric limits: the most negative code is never produced, so |acc| fits w-1 bits.
  function automatic longint facq_sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint facq_sat_min(input int w);
    return -facq_sat_max(w);
  endfunction

endpackage

// File: rtl/facq_prn_corr_if.sv
// Configuration, PRN/sample stream and dump-report signals of facq_prn_corr.
// master = the driving side (search controller + PRN reader), slave = the correlator.
interface facq_prn_corr_if #(
  parameter int SAMPLE_WIDTH = 3,
  parameter int ACC_WIDTH    = 24,
  parameter int LEN_WIDTH    = 16
);
  logic                           start;
  logic        [LEN_WIDTH-1:0]    corr_len;
  logic        [LEN_WIDTH-1:0]    num_dumps;
  logic                           prn;
  logic                           prn_valid;
  logic                           prn_en;
  logic signed [SAMPLE_WIDTH-1:0] sample;
  logic                           busy;
  logic                           done;
  logic                           dump_valid;
  logic signed [ACC_WIDTH-1:0]    dump_acc;
  logic        [LEN_WIDTH-1:0]    dump_idx;
  logic        [ACC_WIDTH-1:0]    peak_acc;
  logic        [LEN_WIDTH-1:0]    peak_idx;

  modport master (
    output start, corr_len, num_dumps, prn, prn_valid, prn_en, sample,
    input  busy, done, dump_valid, dump_acc, dump_idx, peak_acc, peak_idx
  );

  modport slave (
    input  start, corr_len, num_dumps, prn, prn_valid, prn_en, sample,
    output busy, done, dump_valid, dump_acc, dump_idx, peak_acc, peak_idx
  );
endinterface

// File: rtl/facq_sat_acc.sv
// Signed saturating accumulator: clr zeroes it, load starts a new sum with din.
// Once a sum clamps it stays clamped until the next load or clear.
module facq_sat_acc
  import facq_pkg::*;
#(
  parameter int ACC_WIDTH = FACQ_ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        clr,
  input  logic                        en,
  input  logic                        load,
  input  logic signed [ACC_WIDTH-1:0] din,
  output logic signed [ACC_WIDTH-1:0] acc
);
  localparam logic signed [ACC_WIDTH:0] MAX_EXT = (ACC_WIDTH+1)'(facq_sat_max(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH:0] MIN_EXT = (ACC_WIDTH+1)'(facq_sat_min(ACC_WIDTH));

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        sat_q, sat_d;
  logic signed [ACC_WIDTH:0]   sum;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    sum   = load ? {din[ACC_WIDTH-1], din}
                 : {acc_q[ACC_WIDTH-1], acc_q} + {din[ACC_WIDTH-1], din};
    if (clr) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (en && (load || !sat_q)) begin
      if (sum > MAX_EXT) begin
        acc_d = MAX_EXT[ACC_WIDTH-1:0];
        sat_d = 1'b1;
      end else if (sum < MIN_EXT) begin
        acc_d = MIN_EXT[ACC_WIDTH-1:0];
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_WIDTH-1:0];
        sat_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign acc = acc_q;
endmodule

// File: rtl/facq_prn_corr.sv
// PRN despreading correlator: +/-1 chip times sample, corr_len products per dump,
// num_dumps dumps per run. Define FACQ_PRN_CORR_PEAK_EN to add peak-dump tracking.
module facq_prn_corr
  import facq_pkg::*;
#(
  parameter int SAMPLE_WIDTH = FACQ_SAMPLE_WIDTH,
  parameter int ACC_WIDTH    = FACQ_ACC_WIDTH,
  parameter int LEN_WIDTH    = FACQ_LEN_WIDTH
) (
  input  logic            clk,
  input  logic            resetn,
  facq_prn_corr_if.slave  bus
);
  facq_corr_state_t            state_q, state_d;
  logic [LEN_WIDTH-1:0]        len_q, len_d, ndump_q, ndump_d;
  logic [LEN_WIDTH-1:0]        cnt_q, cnt_d, dcnt_q, dcnt_d;
  logic                        tail_q, tail_d, s1_vld_q, s1_vld_d, pend_q, pend_d;
  logic signed [ACC_WIDTH-1:0] s1_prod_q, s1_prod_d, samp_ext, acc;
  logic                        dump_valid_q, dump_valid_d, dump_last_q, dump_last_d;
  logic signed [ACC_WIDTH-1:0] dump_acc_q, dump_acc_d;
  logic [LEN_WIDTH-1:0]        dump_idx_q, dump_idx_d;
  logic                        accept, clr, add, last_add, flush_go;

  // tail_q closes the input once the last product of the run has been accumulated.
  assign accept   = (state_q == RUN) && !tail_q;
  assign clr      = (state_q == IDLE) && bus.start;
  assign add      = s1_vld_q && accept;
  assign last_add = add && (cnt_q == len_q - LEN_WIDTH'(1));
  assign samp_ext = {{(ACC_WIDTH-SAMPLE_WIDTH){bus.sample[SAMPLE_WIDTH-1]}}, bus.sample};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ndump_d = ndump_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = RUN;
        len_d   = (bus.corr_len  == '0) ? LEN_WIDTH'(1) : bus.corr_len;
        ndump_d = (bus.num_dumps == '0) ? LEN_WIDTH'(1) : bus.num_dumps;
      end
      RUN:     if (flush_go) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_vld_d  = accept && bus.prn_valid;
    s1_prod_d = !bus.prn_en ? '0 : (bus.prn ? -samp_ext : samp_ext);
    pend_d    = last_add;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    tail_d    = tail_q;
    if (clr) begin
      cnt_d  = '0;
      dcnt_d = '0;
      tail_d = 1'b0;
    end else if (add) begin
      cnt_d = last_add ? '0 : cnt_q + LEN_WIDTH'(1);
      if (last_add) begin
        dcnt_d = dcnt_q + LEN_WIDTH'(1);
        tail_d = (dcnt_q == ndump_q - LEN_WIDTH'(1));
      end
    end
  end

  // The accumulator still holds the finished sum on the edge after last_add.
  always_comb begin
    dump_valid_d = pend_q;
    dump_acc_d   = dump_acc_q;
    dump_idx_d   = dump_idx_q;
    dump_last_d  = dump_last_q;
    if (pend_q) begin
      dump_acc_d  = acc;
      dump_idx_d  = dcnt_q - LEN_WIDTH'(1);
      dump_last_d = (dcnt_q == ndump_q);
    end
  end

  facq_sat_acc #(.ACC_WIDTH(ACC_WIDTH)) u_acc (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr),
    .en     (add),
    .load   (cnt_q == '0),
    .din    (s1_prod_q),
    .acc    (acc)
  );

  // NOTE: every register is cleared by the asynchronous reset so a mid-run reset leaves no stale run state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      len_q        <= '0;
      ndump_q      <= '0;
      cnt_q        <= '0;
      dcnt_q       <= '0;
      tail_q       <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_prod_q    <= '0;
      pend_q       <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_acc_q   <= '0;
      dump_idx_q   <= '0;
      dump_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      ndump_q      <= ndump_d;
      cnt_q        <= cnt_d;
      dcnt_q       <= dcnt_d;
      tail_q       <= tail_d;
      s1_vld_q     <= s1_vld_d;
      s1_prod_q    <= s1_prod_d;
      pend_q       <= pend_d;
      dump_valid_q <= dump_valid_d;
      dump_acc_q   <= dump_acc_d;
      dump_idx_q   <= dump_idx_d;
      dump_last_q  <= dump_last_d;
    end
  end

`ifdef FACQ_PRN_CORR_PEAK_EN
  logic [ACC_WIDTH-1:0] peak_acc_q, peak_acc_d, mag;
  logic [LEN_WIDTH-1:0] peak_idx_q, peak_idx_d;
  logic                 fin_q, fin_d;

  // Strictly-greater compare keeps the earliest index on ties.
  always_comb begin
    mag        = dump_acc_q[ACC_WIDTH-1] ? -dump_acc_q : dump_acc_q;
    peak_acc_d = peak_acc_q;
    peak_idx_d = peak_idx_q;
    fin_d      = dump_valid_q && dump_last_q;
    if (clr) begin
      peak_acc_d = '0;
      peak_idx_d = '0;
    end else if (dump_valid_q && (mag > peak_acc_q)) begin
      peak_acc_d = mag;
      peak_idx_d = dump_idx_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      peak_acc_q <= '0;
      peak_idx_q <= '0;
      fin_q      <= 1'b0;
    end else begin
      peak_acc_q <= peak_acc_d;
      peak_idx_q <= peak_idx_d;
      fin_q      <= fin_d;
    end
  end

  assign flush_go     = fin_q;
  assign bus.peak_acc = peak_acc_q;
  assign bus.peak_idx = peak_idx_q;
`else
  assign flush_go     = dump_valid_q && dump_last_q;
  assign bus.peak_acc = '0;
  assign bus.peak_idx = '0;
`endif

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == FLUSH);
  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_acc   = dump_acc_q;
  assign bus.dump_idx   = dump_idx_q;
endmodule

// File: tb/tb_facq_prn_corr.sv
// Self-checking bench for facq_prn_corr: a 24-bit and an 8-bit accumulator instance
// share one stimulus; dumps, timing and peaks are compared with a sum-of-products model.
module tb_facq_prn_corr;
  import facq_pkg::*;

  localparam int SW  = 3;
  localparam int LW  = 16;
  localparam int AW  = 24;
  localparam int AW8 = 8;
`ifdef FACQ_PRN_CORR_PEAK_EN
  localparam int DONE_LAT = 2;
  localparam bit PEAK_ON  = 1'b1;
`else
  localparam int DONE_LAT = 1;
  localparam bit PEAK_ON  = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic                 start = 1'b0, prn = 1'b0, prn_valid = 1'b0, prn_en = 1'b1;
  logic signed [SW-1:0] sample = '0;
  logic [LW-1:0]        corr_len = '0, num_dumps = '0;

  facq_prn_corr_if #(.SAMPLE_WIDTH(SW), .ACC_WIDTH(AW),  .LEN_WIDTH(LW)) bus24 ();
  facq_prn_corr_if #(.SAMPLE_WIDTH(SW), .ACC_WIDTH(AW8), .LEN_WIDTH(LW)) bus8 ();

  assign bus24.start = start;      assign bus8.start = start;
  assign bus24.corr_len = corr_len;  assign bus8.corr_len = corr_len;
  assign bus24.num_dumps = num_dumps; assign bus8.num_dumps = num_dumps;
  assign bus24.prn = prn;          assign bus8.prn = prn;
  assign bus24.prn_valid = prn_valid; assign bus8.prn_valid = prn_valid;
  assign bus24.prn_en = prn_en;    assign bus8.prn_en = prn_en;
  assign bus24.sample = sample;    assign bus8.sample = sample;

  facq_prn_corr #(.SAMPLE_WIDTH(SW), .ACC_WIDTH(AW),  .LEN_WIDTH(LW)) dut  (.clk(clk), .resetn(resetn), .bus(bus24));
  facq_prn_corr #(.SAMPLE_WIDTH(SW), .ACC_WIDTH(AW8), .LEN_WIDTH(LW)) dut8 (.clk(clk), .resetn(resetn), .bus(bus8));

  typedef struct {
    logic signed [SW-1:0] s;
    bit                   p;
    bit                   en;
  } stim_t;

  stim_t  stim[$];
  longint d24_acc[$], d8_acc[$];
  int     d24_idx[$], d24_cyc[$], edge_of[$], done_cyc[$];
  bit     done_busy[$];
  int     cyc = 0;
  int     n_cmp = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus24.dump_valid === 1'b1) begin
      d24_acc.push_back(longint'(bus24.dump_acc));
      d24_idx.push_back(int'(bus24.dump_idx));
      d24_cyc.push_back(cyc);
    end
    if (bus8.dump_valid === 1'b1) d8_acc.push_back(longint'(bus8.dump_acc));
    if (bus24.done === 1'b1) begin
      done_cyc.push_back(cyc);
      done_busy.push_back(bus24.busy);
    end
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint prod(input stim_t x);
    if (!x.en) return 0;
    return x.p ? -longint'(x.s) : longint'(x.s);
  endfunction

  // Sum of one dump's products, clamped to +/-(2^(w-1)-1) and held once clamped.
  function automatic longint dump_val(input int d, input int len, input int w);
    longint sum = 0;
    longint m   = (longint'(1) <<< (w - 1)) - 1;
    bit     sat = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (!sat) begin
        sum += prod(stim[d*len + k]);
        if (sum > m) begin sum = m; sat = 1'b1; end
        else if (sum < -m) begin sum = -m; sat = 1'b1; end
      end
    end
    return sum;
  endfunction

  task automatic add_stim(input int s, input bit p, input bit en);
    stim_t x;
    x.s = SW'(s); x.p = p; x.en = en;
    stim.push_back(x);
  endtask

  task automatic rand_stim(input int n, input bit en_on);
    stim.delete();
    for (int i = 0; i < n; i++)
      add_stim(int'($urandom_range(0, 7)) - 4, 1'($urandom), en_on && ($urandom_range(0, 3) != 0));
  endtask

  task automatic pulse_start(input int len_in, input int nd_in);
    d24_acc.delete(); d8_acc.delete(); d24_idx.delete(); d24_cyc.delete();
    edge_of.delete(); done_cyc.delete(); done_busy.delete();
    @(posedge clk); #1;
    start = 1'b1; corr_len = LW'(len_in); num_dumps = LW'(nd_in);
    @(posedge clk); #1;
    start = 1'b0; corr_len = LW'($urandom); num_dumps = LW'($urandom);
    check("busy_after_start", bus24.busy, 1);
  endtask

  task automatic drive(input int total, input int gap, input bit mid_start);
    for (int i = 0; i < total; i++) begin
      prn_valid = 1'b1; sample = stim[i].s; prn = stim[i].p; prn_en = stim[i].en;
      start = mid_start && (i == 1);
      edge_of.push_back(cyc + 1);
      @(posedge clk); #1;
      prn_valid = 1'b0; start = 1'b0;
      sample = SW'($urandom); prn = 1'($urandom); prn_en = 1'($urandom);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic finish_run(input string tag, input int len_in, input int nd_in);
    int     len = (len_in == 0) ? 1 : len_in;
    int     nd  = (nd_in == 0) ? 1 : nd_in;
    longint e24, e8, mag;
    longint pk24 = 0, pk8 = 0;
    int     pi24 = 0, pi8 = 0;
    for (int i = 0; i < 400 && done_cyc.size() == 0; i++) @(negedge clk);
    check({tag, " n_dumps24"}, d24_acc.size(), nd);
    check({tag, " n_dumps8"}, d8_acc.size(), nd);
    for (int d = 0; d < nd; d++) begin
      e24 = dump_val(d, len, AW);
      e8  = dump_val(d, len, AW8);
      if (d < d24_acc.size()) begin
        check($sformatf("%s acc24[%0d]", tag, d), d24_acc[d], e24);
        check($sformatf("%s idx[%0d]", tag, d), d24_idx[d], d);
        check($sformatf("%s dump_cyc[%0d]", tag, d), d24_cyc[d], edge_of[(d+1)*len - 1] + 2);
      end
      if (d < d8_acc.size()) check($sformatf("%s acc8[%0d]", tag, d), d8_acc[d], e8);
      mag = (e24 < 0) ? -e24 : e24;
      if (PEAK_ON && mag > pk24) begin pk24 = mag; pi24 = d; end
      mag = (e8 < 0) ? -e8 : e8;
      if (PEAK_ON && mag > pk8) begin pk8 = mag; pi8 = d; end
    end
    check({tag, " peak_acc24"}, bus24.peak_acc, pk24);
    check({tag, " peak_idx24"}, bus24.peak_idx, pi24);
    check({tag, " peak_acc8"}, bus8.peak_acc, pk8);
    check({tag, " peak_idx8"}, bus8.peak_idx, pi8);
    check({tag, " n_done"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) begin
      check({tag, " done_cyc"}, done_cyc[0], edge_of[nd*len - 1] + 2 + DONE_LAT);
      check({tag, " busy_at_done"}, done_busy[0], 0);
    end
  endtask

  task automatic run_case(input string tag, input int len_in, input int nd_in,
                          input int gap, input int extra, input bit mid_start);
    int len = (len_in == 0) ? 1 : len_in;
    int nd  = (nd_in == 0) ? 1 : nd_in;
    pulse_start(len_in, nd_in);
    drive(len*nd + extra, gap, mid_start);
    finish_run(tag, len_in, nd_in);
  endtask

  initial begin
    int len, nd, gap, extra;

    repeat (3) @(posedge clk);
    #1;
    check("rst busy", bus24.busy, 0);
    check("rst done", bus24.done, 0);
    check("rst dump_valid", bus24.dump_valid, 0);
    check("rst dump_acc", bus24.dump_acc, 0);
    check("rst dump_idx", bus24.dump_idx, 0);
    check("rst peak_acc", bus24.peak_acc, 0);
    check("rst peak_idx", bus24.peak_idx, 0);
    check("rst dump_acc8", bus8.dump_acc, 0);
    @(negedge clk);
    resetn = 1'b1;

    // +3 with chips 0,1,0,0 -> 3-3+3+3 = 6
    stim.delete();
    add_stim(3, 0, 1); add_stim(3, 1, 1); add_stim(3, 0, 1); add_stim(3, 0, 1);
    run_case("basic", 4, 1, 0, 0, 1'b0);

    // corr_len 0 behaves as 1
    stim.delete();
    add_stim(1, 0, 1); add_stim(-2, 0, 1); add_stim(3, 0, 1);
    run_case("len0", 0, 3, 0, 0, 1'b0);

    // 300 in 24 bits, clamps at +127 in 8 bits
    stim.delete();
    repeat (100) add_stim(3, 0, 1);
    run_case("sat", 100, 1, 0, 0, 1'b0);

    // +5 then -5: tie keeps index 0
    stim.delete();
    add_stim(3, 0, 1); add_stim(2, 0, 1); add_stim(3, 1, 1); add_stim(2, 1, 1);
    run_case("tie", 2, 2, 0, 0, 1'b0);

    rand_stim(7, 1'b0);
    run_case("prn_en_off", 3, 2, 0, 1, 1'b0);

    rand_stim(4, 1'b1);
    run_case("gapped", 2, 2, 2, 0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      len   = int'($urandom_range(1, 6));
      nd    = int'($urandom_range(1, 4));
      gap   = int'($urandom_range(0, 2));
      extra = int'($urandom_range(0, 2));
      rand_stim(len*nd + extra, 1'b1);
      run_case($sformatf("rand%0d", r), len, nd, gap, extra, 1'b0);
    end

    // Reset in the middle of a run, away from any clock edge
    stim.delete();
    repeat (6) add_stim(3, 0, 1);
    pulse_start(2, 3);
    drive(4, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst dump_acc", bus24.dump_acc, 6);
    check("pre_rst dump_idx", bus24.dump_idx, 1);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst busy", bus24.busy, 0);
    check("mid_rst dump_acc", bus24.dump_acc, 0);
    check("mid_rst dump_idx", bus24.dump_idx, 0);
    check("mid_rst peak_acc", bus24.peak_acc, 0);
    check("mid_rst dump_valid", bus24.dump_valid, 0);
    @(negedge clk);
    resetn = 1'b1;

    rand_stim(6, 1'b1);
    run_case("post_rst", 3, 2, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
